ifu: RTL
========

# ifu

Instruction fetch unit for the single-cycle MIPS core: holds the PC, reads the instruction word from an internal instruction memory and computes the next PC. It is the producer end of the `instr` bus that the control decoder consumes, and it acts on the decoder's `branch`, `JType` and `JReg` outputs. A write port lets the bench or boot logic preload the instruction memory.

## Interface

**Parameters**
- `PC_RESET`, default `32'h0000_3000`: PC value after reset; base address of the instruction memory.
- `IM_DEPTH`, default `1024`: instruction memory depth in 32-bit words. Must be a power of two.

**Ports**
- `clk` (input, 1): the single clock; all state updates on the rising edge.
- `reset` (input, 1): asynchronous, active-low.
- `en` (input, 1): advance enable. When low, PC holds (stall).
- `branch` (input, 1): take branch. This is the decoder's `beq & eq`.
- `JType` (input, 1): `j`/`jal` target.
- `JReg` (input, 1): `jr`/`jalr` target.
- `ra` (input, 32): GPR[rs], the register jump target.
- `im_we` (input, 1): instruction-memory write enable.
- `im_addr` (input, 32): byte address of the write; `PC_RESET`-relative.
- `im_wdata` (input, 32): word to write.
- `instr` (output, 32): instruction at the current PC.
- `PC` (output, 32): current PC.
- `PC4` (output, 32): `PC + 4`, used for the link value.
- `fault` (output, 1): sticky fetch fault.

## Operation

**State machine: RUN and FAULT**
- Reset enters RUN.
- RUN → FAULT on the rising edge where `en=1` and the selected next PC is misaligned (`npc[1:0]!=0`) or outside the window `[PC_RESET, PC_RESET + 4*IM_DEPTH)`.
- In the fault case, PC is not updated.
- FAULT is left only by reset.

**Next PC, in priority order** (the decoder keeps the selects one-hot; the priority defines behaviour when they are not)
- `JReg`: `ra`.
- `JType`: `{PC4[31:28], instr[25:0], 2'b00}`.
- `branch`: `PC4 + {{14{instr[15]}}, instr[15:0], 2'b00}`, computed in 32-bit modulo arithmetic.
- Otherwise: `PC4`.

**Fetch**
- `instr = mem[(PC - PC_RESET)[log2(IM_DEPTH)+1:2]]`, read combinationally.
- In FAULT, `instr = 32'h0000_0000` (nop).

**Memory write**
- When `im_we=1` and `im_addr` is inside the window, the word at index `(im_addr - PC_RESET)>>2` is written at the clock edge. `im_addr[1:0]` is ignored.
- Writes outside the window are dropped silently.
- Writes are accepted in every state, regardless of `en`.

**Reset values**
- `PC = PC_RESET`, `PC4 = PC_RESET + 4`, `fault = 0`, state = RUN.
- Memory contents are not cleared by reset.

## Timing

- Single cycle: `instr`, `PC4` and the next-PC mux are combinational from `PC`. PC updates one edge after the selects are presented.
- `en=0`: PC, state and `fault` all hold; memory writes still occur.
- Write/read collision: a write to the word currently addressed by PC shows on `instr` only after the edge. Same-cycle `instr` shows the old data.
- Wrap-around: a sequential step from the last word (`PC_RESET + 4*IM_DEPTH - 4`) is out of window and enters FAULT; PC stays at the last word.
- Reset asserted mid-cycle forces the reset values immediately, independent of `clk`. Deassertion takes effect at the next edge.
- `fault` rises on the same edge as the RUN → FAULT transition.

## Structure

- Shared package `mips_pkg` holds:
  - `PC_RESET_DEFAULT`
  - opcode/funct constants for `j`, `jal`, `jr`, `jalr`, `beq`
  - the state encoding `ifu_state_t` (`RUN`, `FAULT`)
- One sub-module, `ifu_imem`: a `IM_DEPTH` × 32 array with an asynchronous read port and a synchronous write port.
- `ifu` contains the PC register, the state register, the next-PC mux and the window/alignment check.

## Test plan

- Reset, then sequential fetch: preload words 0..3 with `0x3402_0001..0x3402_0004`, release reset, `en=1`, no selects → PC = 3000, 3004, 3008, 300C and `instr` matches each word.
- Branch: at PC `0x3004`, `instr=0x1000_FFFF`, `branch=1` → next PC `0x3004`. With `instr=0x1000_0002` → next PC `0x3010`.
- Jumps: `JType=1`, `instr=0x0800_0C10` → next PC `0x0000_3040`. `JReg=1`, `ra=0x3100` → next PC `0x3100`. `JReg` and `JType` both high → `ra` wins.
- Faults: `JReg=1`, `ra=0x3102` → `fault=1`, PC holds, `instr=0`. Fault stays set with `en` toggling until `reset=0`. Also check `ra=0x2FFC` and a sequential step past the last word.
- Stall and write: `en=0` for 3 cycles → PC unchanged. Write `0xFFFF_FFFF` to the current PC's word → `instr` changes only after the edge. Write to `0x5000` → no effect.
- Asynchronous reset: pulse `reset` low between edges while PC=`0x3040` → PC reads `0x3000` before the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: reset PC, the opcode and
// funct values of the control-flow instructions, and the fetch-unit states.
package mips_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;

    // SPECIAL funct codes (instr[5:0])
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_JALR = 6'h09;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } ifu_state_t;

endpackage

// File: rtl/ifu_imem.sv
// Instruction memory: DEPTH x 32 words, combinational read port and a
// synchronous write port. Contents are deliberately not reset.
module ifu_imem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Write port: the new word becomes visible on the read port after the edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, RUN/FAULT state, next-PC selection,
// fetch-window/alignment check and the preload write port into ifu_imem.
module ifu
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        branch,
    input  logic        JType,
    input  logic        JReg,
    input  logic [31:0] ra,
    input  logic        im_we,
    input  logic [31:0] im_addr,
    input  logic [31:0] im_wdata,
    output logic [31:0] instr,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        fault
);

    localparam int          AW        = $clog2(IM_DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(4 * IM_DEPTH);

    logic [31:0]   pc_q;
    ifu_state_t    state;

    logic [31:0]   pc_off;
    logic [AW-1:0] rd_idx;
    logic [31:0]   mem_word;

    logic [31:0]   br_off;
    logic [31:0]   npc;
    logic [31:0]   npc_off;
    logic          npc_ok;

    logic [31:0]   w_off;
    logic          w_ok;
    logic [AW-1:0] w_idx;

    // Offsets are taken relative to the window base; an address below the base
    // wraps to a huge unsigned offset, so one compare covers both window ends.
    assign pc_off  = pc_q - PC_RESET;
    assign rd_idx  = AW'(pc_off >> 2);

    assign w_off   = im_addr - PC_RESET;
    assign w_ok    = (w_off < WIN_BYTES);
    assign w_idx   = AW'(w_off >> 2);

    ifu_imem #(
        .DEPTH (IM_DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk   (clk),
        .we    (im_we & w_ok),
        .waddr (w_idx),
        .wdata (im_wdata),
        .raddr (rd_idx),
        .rdata (mem_word)
    );

    assign PC    = pc_q;
    assign PC4   = pc_q + 32'd4;
    assign fault = (state == FAULT);
    assign instr = (state == FAULT) ? 32'h0000_0000 : mem_word;

    assign br_off = {{14{mem_word[15]}}, mem_word[15:0], 2'b00};

    // Next-PC mux; JReg beats JType beats branch if the selects ever overlap
    always_comb begin
        npc = PC4;
        if (JReg) begin
            npc = ra;
        end else if (JType) begin
            npc = {PC4[31:28], mem_word[25:0], 2'b00};
        end else if (branch) begin
            npc = PC4 + br_off;
        end
    end

    assign npc_off = npc - PC_RESET;
    assign npc_ok  = (npc[1:0] == 2'b00) && (npc_off < WIN_BYTES);

    // PC and state: a bad target freezes PC and latches FAULT until reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= PC_RESET;
            state <= RUN;
        end else if (en && state == RUN) begin
            if (npc_ok) begin
                pc_q <= npc;
            end else begin
                state <= FAULT;
            end
        end
    end

endmodule
